// File: rtl/fpu_f2i_arbiter.sv
// Round-robin arbiter sharing one pipelined F32->INT32 converter among N_REQ requesters.
// Define FPU_F2I_ARB_PERF_EN to add the PERF_STALL / PERF_ISSUE saturating counters.
module fpu_f2i_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2,
  localparam int TAG_W  = $clog2(N_REQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [32*N_REQ-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]     REQ_READY,
  output logic [N_REQ-1:0]     RSP_VALID,
  output logic [31:0]          RSP_DATA,
  input  logic [N_REQ-1:0]     RSP_READY,
  output logic [31:0]          FPU_A,
  output logic                 FPU_VALID,
  output logic                 FPU_EN,
  input  logic [31:0]          FPU_O
`ifdef FPU_F2I_ARB_PERF_EN
  ,
  output logic [31:0]          PERF_STALL,
  output logic [31:0]          PERF_ISSUE
`endif
);

  logic             r_vld_p [LATENCY];
  logic [TAG_W-1:0] r_tag_p [LATENCY];
  logic [TAG_W-1:0] r_rr_ptr;

  logic             w_hv;
  logic [TAG_W-1:0] w_ht;
  logic             w_stall;
  logic             w_gnt;
  logic [TAG_W-1:0] w_gnt_idx;
  logic [TAG_W:0]   w_sum;
  logic [TAG_W-1:0] w_idx;

  assign w_hv    = r_vld_p[LATENCY-1];
  assign w_ht    = r_tag_p[LATENCY-1];
  assign w_stall = w_hv & ~RSP_READY[w_ht];

  // Reset forces the converter stages to advance so stale data flushes out.
  assign FPU_EN   = RST | ~w_stall;
  assign RSP_DATA = FPU_O;

  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
      if (w_sum >= (TAG_W+1)'(N_REQ))
        w_sum = w_sum - (TAG_W+1)'(N_REQ);
      w_idx = w_sum[TAG_W-1:0];
      if (!w_gnt && REQ_VALID[w_idx]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (RST || w_stall) begin
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
    end
  end

  always_comb begin
    REQ_READY = '0;
    RSP_VALID = '0;
    FPU_A     = '0;
    FPU_VALID = w_gnt;
    for (int i = 0; i < N_REQ; i++) begin
      REQ_READY[i] = w_gnt && (w_gnt_idx == TAG_W'(i));
      RSP_VALID[i] = !RST && w_hv && (w_ht == TAG_W'(i));
      if (w_gnt && (w_gnt_idx == TAG_W'(i)))
        FPU_A = REQ_DATA[32*i +: 32];
    end
  end

  // Issue stage -> tag/valid pipeline, advanced in lockstep with the converter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_ptr <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_vld_p[i] <= 1'b0;
        r_tag_p[i] <= '0;
      end
    end else if (FPU_EN) begin
      r_vld_p[0] <= w_gnt;
      r_tag_p[0] <= w_gnt_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_tag_p[i] <= r_tag_p[i-1];
      end
      if (w_gnt)
        r_rr_ptr <= (w_gnt_idx == TAG_W'(N_REQ-1)) ? '0 : w_gnt_idx + TAG_W'(1);
    end
  end

`ifdef FPU_F2I_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_issue;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_stall <= '0;
      r_perf_issue <= '0;
    end else begin
      if ((|REQ_VALID) && !(|REQ_READY) && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_gnt && (r_perf_issue != 32'hFFFF_FFFF))
        r_perf_issue <= r_perf_issue + 32'd1;
    end
  end

  assign PERF_STALL = r_perf_stall;
  assign PERF_ISSUE = r_perf_issue;
`endif

endmodule

// File: tb/tb_fpu_f2i_arbiter.sv
// Randomized + directed bench for fpu_f2i_arbiter with a transaction-level reference model.
module tb_fpu_f2i_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_VALID;
  logic [32*N-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic [N-1:0]    RSP_VALID;
  logic [31:0]     RSP_DATA;
  logic [N-1:0]    RSP_READY;
  logic [31:0]     FPU_A;
  logic            FPU_VALID;
  logic            FPU_EN;
  logic [31:0]     FPU_O;
`ifdef FPU_F2I_ARB_PERF_EN
  logic [31:0]     PERF_STALL;
  logic [31:0]     PERF_ISSUE;
`endif

  always #5 CLK = ~CLK;

  fpu_f2i_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_READY(RSP_READY),
    .FPU_A(FPU_A), .FPU_VALID(FPU_VALID), .FPU_EN(FPU_EN), .FPU_O(FPU_O)
`ifdef FPU_F2I_ARB_PERF_EN
    , .PERF_STALL(PERF_STALL), .PERF_ISSUE(PERF_ISSUE)
`endif
  );

  // Converter stand-in: bit-level truncating F32->INT32 with LAT enable-gated stages.
  function automatic logic [31:0] f2i_core(input logic [31:0] f);
    logic [31:0] m;
    logic [31:0] mag;
    int e;
    e = int'(f[30:23]);
    m = {8'd0, 1'b1, f[22:0]};
    if (e < 127)       mag = 32'd0;
    else if (e >= 150) mag = m << (e - 150);
    else               mag = m >> (150 - e);
    return f[31] ? (32'd0 - mag) : mag;
  endfunction

  logic [31:0] cvt_p [LAT];
  always @(posedge CLK) begin
    if (FPU_EN) begin
      cvt_p[0] <= f2i_core(FPU_A);
      for (int k = 1; k < LAT; k++) cvt_p[k] <= cvt_p[k-1];
    end
  end
  assign FPU_O = cvt_p[LAT-1];

  // Reference conversion computed numerically: value = 1.frac * 2^(e-127), truncated toward zero.
  function automatic logic [31:0] ref_f2i(input logic [31:0] f);
    int  e;
    real v;
    int  r;
    e = int'(f[30:23]);
    if (e == 0) return 32'd0;
    v = real'(int'({8'd0, 1'b1, f[22:0]}));
    for (int k = 150; k < e; k++) v = v * 2.0;
    for (int k = e; k < 150; k++) v = v / 2.0;
    r = $rtoi(v);
    if (f[31]) r = -r;
    return 32'(r);
  endfunction

  typedef struct {
    int          tag;
    logic [31:0] res;
    int          age;
  } item_t;

  item_t       q[$];
  int          m_rr;
  int          n_vec;
  int          n_err;
  logic [31:0] m_pstall;
  logic [31:0] m_pissue;
  logic [31:0] ops [N];
  logic [31:0] tbl [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_f32();
    logic [31:0] f;
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 3)];
    f[31]    = 1'($urandom_range(0, 1));
    f[30:23] = 8'($urandom_range(100, 157));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  // One clock cycle: drive, check against the model at the falling edge, then advance the model.
  task automatic apply(input logic rst, input logic [N-1:0] vld, input logic [N-1:0] rdy);
    bit    head;
    bit    stall;
    int    gnt;
    int    idx;
    logic [31:0] exp_rv;
    @(posedge CLK);
    #1;
    RST       = rst;
    REQ_VALID = vld;
    RSP_READY = rdy;
    for (int i = 0; i < N; i++) REQ_DATA[32*i +: 32] = ops[i];
    @(negedge CLK);
`ifdef FPU_F2I_ARB_PERF_EN
    check_eq("perf_stall", PERF_STALL, m_pstall);
    check_eq("perf_issue", PERF_ISSUE, m_pissue);
`endif
    if (rst) begin
      check_eq("rst_req_ready", 32'(REQ_READY), 32'd0);
      check_eq("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check_eq("rst_fpu_valid", 32'(FPU_VALID), 32'd0);
      check_eq("rst_fpu_en", 32'(FPU_EN), 32'd1);
      check_eq("rst_fpu_a", FPU_A, 32'd0);
      q.delete();
      m_rr     = 0;
      m_pstall = 32'd0;
      m_pissue = 32'd0;
    end else begin
      head   = (q.size() > 0) && (q[0].age == LAT);
      stall  = head && !rdy[q[0].tag];
      exp_rv = head ? (32'd1 << q[0].tag) : 32'd0;
      check_eq("rsp_valid", 32'(RSP_VALID), exp_rv);
      if (head) check_eq("rsp_data", RSP_DATA, q[0].res);
      check_eq("fpu_en", 32'(FPU_EN), stall ? 32'd0 : 32'd1);
      gnt = -1;
      if (!stall)
        for (int off = 0; off < N; off++) begin
          idx = (m_rr + off) % N;
          if (gnt < 0 && vld[idx]) gnt = idx;
        end
      check_eq("req_ready", 32'(REQ_READY), (gnt >= 0) ? (32'd1 << gnt) : 32'd0);
      check_eq("fpu_valid", 32'(FPU_VALID), (gnt >= 0) ? 32'd1 : 32'd0);
      check_eq("fpu_a", FPU_A, (gnt >= 0) ? ops[gnt] : 32'd0);
      if ((|vld) && gnt < 0) m_pstall = m_pstall + 32'd1;
      if (gnt >= 0) m_pissue = m_pissue + 32'd1;
      if (!stall) begin
        if (head) void'(q.pop_front());
        if (gnt >= 0) begin
          q.push_back('{tag: gnt, res: ref_f2i(ops[gnt]), age: 0});
          m_rr = (gnt + 1) % N;
        end
        foreach (q[i]) q[i].age++;
      end
    end
  endtask

  logic [31:0] rr_res [4];
  logic [31:0] p0;
  logic [N-1:0] rv;
  logic [N-1:0] rr;

  initial begin
    n_vec = 0; n_err = 0; m_rr = 0;
    m_pstall = 32'd0; m_pissue = 32'd0;
    tbl[0] = 32'hC020_0000; tbl[1] = 32'h3F80_0000;
    tbl[2] = 32'h42F6_0000; tbl[3] = 32'h0000_0000;
    rr_res[0] = 32'hFFFF_FFFE; rr_res[1] = 32'd1; rr_res[2] = 32'd123; rr_res[3] = 32'd0;
    p0 = 32'd0;
    RST = 1'b1; REQ_VALID = '0; RSP_READY = '1; REQ_DATA = '0;
    for (int i = 0; i < N; i++) ops[i] = 32'd0;

    // Single issue
    apply(1'b1, 4'b0000, 4'b1111);
    apply(1'b1, 4'b0000, 4'b1111);
    ops[0] = 32'h4049_0FDB;
    apply(1'b0, 4'b0001, 4'b1111);
    check_eq("s1_ready", 32'(REQ_READY), 32'd1);
    apply(1'b0, 4'b0000, 4'b1111);
    apply(1'b0, 4'b0000, 4'b1111);
    check_eq("s1_rsp_valid", 32'(RSP_VALID), 32'd1);
    check_eq("s1_rsp_data", RSP_DATA, 32'd3);

    // Round-robin over all four with fixed operands
    apply(1'b1, 4'b0000, 4'b1111);
    for (int i = 0; i < N; i++) ops[i] = tbl[i];
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, (c < 8) ? 4'b1111 : 4'b0000, 4'b1111);
      if (c < 8) check_eq("rr_grant", 32'(REQ_READY), 32'd1 << (c % 4));
      if (c >= 2) begin
        check_eq("rr_rsp_valid", 32'(RSP_VALID), 32'd1 << ((c - 2) % 4));
        check_eq("rr_rsp_data", RSP_DATA, rr_res[(c - 2) % 4]);
      end
    end

    // Backpressure on requester 2's result
    apply(1'b1, 4'b0000, 4'b1111);
    apply(1'b0, 4'b0100, 4'b1111);
    apply(1'b0, 4'b1011, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 4'b1011, 4'b1011);
`ifdef FPU_F2I_ARB_PERF_EN
      if (c == 0) p0 = PERF_STALL;
`endif
      check_eq("bp_fpu_en", 32'(FPU_EN), 32'd0);
      check_eq("bp_req_ready", 32'(REQ_READY), 32'd0);
      check_eq("bp_rsp_data", RSP_DATA, 32'd123);
    end
    apply(1'b0, 4'b1011, 4'b1111);
    check_eq("bp_release", 32'(RSP_VALID), 32'b0100);
`ifdef FPU_F2I_ARB_PERF_EN
    check_eq("bp_perf_stall_delta", PERF_STALL - p0, 32'd3);
`endif
    apply(1'b0, 4'b0000, 4'b1111);
    check_eq("bp_next", 32'(RSP_VALID), 32'b1000);

    // Fairness between requesters 1 and 3 starting from RR_PTR=2
    apply(1'b1, 4'b0000, 4'b1111);
    apply(1'b0, 4'b0010, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 4'b1010, 4'b1111);
      check_eq("fair_grant", 32'(REQ_READY), (c % 2 == 0) ? 32'b1000 : 32'b0010);
    end

    // Reset with two results in flight
    apply(1'b1, 4'b0000, 4'b1111);
    apply(1'b0, 4'b0001, 4'b1111);
    apply(1'b0, 4'b0010, 4'b1111);
    apply(1'b1, 4'b0000, 4'b1111);
    apply(1'b0, 4'b0000, 4'b1111);
    check_eq("mid_rst_rv0", 32'(RSP_VALID), 32'd0);
    apply(1'b0, 4'b0000, 4'b1111);
    check_eq("mid_rst_rv1", 32'(RSP_VALID), 32'd0);
    ops[0] = 32'h3F80_0000;
    apply(1'b0, 4'b1111, 4'b1111);
    check_eq("mid_rst_ptr0", 32'(REQ_READY), 32'd1);
    apply(1'b0, 4'b0000, 4'b1111);
    apply(1'b0, 4'b0000, 4'b1111);
    check_eq("mid_rst_rv", 32'(RSP_VALID), 32'd1);
    check_eq("mid_rst_data", RSP_DATA, 32'd1);

    // Random traffic with random backpressure and occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ops[i] = rand_f32();
        rv[i]  = 1'($urandom_range(0, 1));
        rr[i]  = ($urandom_range(0, 4) != 0);
      end
      apply($urandom_range(0, 99) == 0, rv, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
